counter_down_timer: RTL

- Loadable down-counter/timer; the decrementing counterpart to the team's up-counter.
- Counts a preloaded value down to zero under an enable.
- Pulses a terminal-count flag when it reaches zero; optionally auto-reloads for periodic ticks.
- Used as a programmable delay/period generator beside the up-counter in the Counter_8b design.

---
 rtl/counter_down_timer_if.sv | 29 ++
 rtl/counter_down_timer.sv | 90 +++++++++
 2 files changed

// File: rtl/counter_down_timer_if.sv
// Bus bundle for the loadable down-counter/timer.
// Control semantics: Load is a single-cycle strobe sampled at the rising
// clock edge. There is no back-pressure, so the timer always accepts it.
// Enable and Reload are level signals that are sampled every cycle.
// TC is a registered pulse, exactly one cycle wide. Q, Zero and Busy
// are status levels. The state field is exported for debug visibility.
interface counter_down_timer_if #(
  parameter int WIDTH = 8
);
  logic             Enable;
  logic             Load;
  logic [WIDTH-1:0] D;
  logic             Reload;
  logic [WIDTH-1:0] Q;
  logic             Zero;
  logic             TC;
  logic             Busy;
  logic [1:0]       state;

  modport master (
    output Enable, Load, D, Reload,
    input  Q, Zero, TC, Busy, state
  );

  modport slave (
    input  Enable, Load, D, Reload,
    output Q, Zero, TC, Busy, state
  );
endinterface

// File: rtl/counter_down_timer.sv
// Loadable down-counter/timer with a one-cycle terminal-count pulse and an
// optional periodic auto-reload. Priority at every edge: Clr > Load > count.
module counter_down_timer #(
  parameter int WIDTH = 8
) (
  input logic                  Clk,
  input logic                  Clr,
  counter_down_timer_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // Next-state logic. A decrement happens only in RUN with Q >= 2. At
  // Q == 1 the counter either reloads or parks at zero, so it cannot
  // underflow.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (bus.Load) begin
      q_d      = bus.D;
      reload_d = bus.D;
      state_d  = (bus.D != '0) ? RUN : DONE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN: begin
          if (q_q == '0) begin
            // Unreachable. RUN is only entered with a non-zero count.
            state_d = DONE;
          end else if (bus.Enable) begin
            if (q_q == WIDTH'(1)) begin
              tc_d = 1'b1;
              if (bus.Reload) begin
                q_d = reload_q;
              end else begin
                q_d     = '0;
                state_d = DONE;
              end
            end else begin
              q_d = q_q - WIDTH'(1);
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
          q_d     = '0;
        end
      endcase
    end
  end

  // State registers with a synchronous clear.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q  <= IDLE;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Output mapping. Zero is decoded from the registered count.
  always_comb begin
    bus.Q     = q_q;
    bus.Zero  = (q_q == '0);
    bus.TC    = tc_q;
    bus.Busy  = (state_q == RUN);
    bus.state = state_q;
  end

endmodule
